// File: rtl/memblock_pkg.sv
// Shared types and byte helpers for the multi-port memory block.
// Helpers operate on MaxWidth-wide words; callers zero-extend and truncate.
package memblock_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int unsigned MaxWidth = 128;
  localparam int unsigned MaxBytes = MaxWidth / 8;

  // Take byte i from new_word where be[i] is set, else from old_word.
  function automatic logic [MaxWidth-1:0] byte_merge(input logic [MaxWidth-1:0] old_word,
                                                     input logic [MaxWidth-1:0] new_word,
                                                     input logic [MaxBytes-1:0] be);
    logic [MaxWidth-1:0] res;
    res = old_word;
    for (int i = 0; i < MaxBytes; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // Even parity: bit i makes byte i plus its parity bit hold an even number of ones.
  function automatic logic [MaxBytes-1:0] byte_parity(input logic [MaxWidth-1:0] word);
    logic [MaxBytes-1:0] par;
    for (int i = 0; i < MaxBytes; i++) begin
      par[i] = ^word[8*i +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/memblock_rdport.sv
// One registered read port: write-first forwarding and out-of-range zeroing.
// MEMBLOCK_PARITY_EN adds per-byte parity checking on the returned word.
module memblock_rdport
  import memblock_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WIDTH-1:0]     arr_word,
  input  logic                 fwd_we,
  input  logic [ADDR_W-1:0]    fwd_addr,
  input  logic [WIDTH-1:0]     fwd_din,
  input  logic [WIDTH/8-1:0]   fwd_be,
`ifdef MEMBLOCK_PARITY_EN
  input  logic [WIDTH/8-1:0]   arr_par,
  output logic                 perr,
`endif
  output logic [WIDTH-1:0]     dout,
  output logic                 valid
);

  localparam int unsigned NB = WIDTH / 8;

  logic             in_range;
  logic             hit;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] rd_word;

  always_comb begin
    in_range = 32'(addr) < DEPTH;
    hit      = fwd_we && (fwd_addr == addr);
    merged   = arr_word;
    if (hit) begin
      merged = WIDTH'(byte_merge(MaxWidth'(arr_word), MaxWidth'(fwd_din), MaxBytes'(fwd_be)));
    end
    rd_word  = in_range ? merged : '0;
  end

`ifdef MEMBLOCK_PARITY_EN
  logic [NB-1:0] par_calc;
  logic [NB-1:0] par_eff;
  logic          mismatch;

  // Forwarded bytes take freshly computed parity, so they never flag.
  always_comb begin
    par_calc = NB'(byte_parity(MaxWidth'(merged)));
    for (int i = 0; i < NB; i++) begin
      par_eff[i] = (hit && fwd_be[i]) ? par_calc[i] : arr_par[i];
    end
    mismatch = in_range && (|(par_eff ^ par_calc));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perr <= 1'b0;
    end else if (accept) begin
      perr <= mismatch;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= accept;
      if (accept) dout <= rd_word;
    end
  end

endmodule

// File: rtl/memblock_mp.sv
// Byte-enabled single-write, NRD-read memory with post-reset hardware clear.
// Define MEMBLOCK_PARITY_EN for per-byte parity storage and read-side checking.
module memblock_mp
  import memblock_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned NRD    = 2,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wr_addr0,
  input  logic [WIDTH-1:0]      wr_din0,
  input  logic [WIDTH/8-1:0]    wr_be0,
`ifdef MEMBLOCK_PARITY_EN
  input  logic                  wr_perr_inj0,
  output logic [NRD-1:0]        rd_perr,
`endif
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*WIDTH-1:0]  rd_dout,
  output logic [NRD-1:0]        rd_valid
);

  localparam int unsigned NB = WIDTH / 8;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ready;
  logic              clr_we;
  logic              wr_active;

  logic [WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = READY;
          clr_cnt_d = '0;
        end
      end
      READY: ;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    init_busy = 1'b0;
    ready     = 1'b0;
    unique case (state_q)
      CLEAR:   init_busy = 1'b1;
      READY:   ready     = 1'b1;
      default: init_busy = 1'b1;
    endcase
  end

  assign clr_we    = !ready && !rst;
  assign wr_active = ready && !rst && we0 && (32'(wr_addr0) < DEPTH);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_active) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be0[i]) mem[wr_addr0][8*i +: 8] <= wr_din0[8*i +: 8];
      end
    end
  end

`ifdef MEMBLOCK_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wr_par;

  // Injection flips byte 0's parity only; all-zero clear words have zero parity.
  assign wr_par = NB'(byte_parity(MaxWidth'(wr_din0))) ^ NB'(wr_perr_inj0);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_cnt_q] <= '0;
    end else if (wr_active) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be0[i]) par_mem[wr_addr0][i] <= wr_par[i];
      end
    end
  end
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    memblock_rdport #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .clk      (clk),
      .rst      (rst),
      .accept   (rd_en[k] && ready),
      .addr     (rd_addr[k*ADDR_W +: ADDR_W]),
      .arr_word (mem[rd_addr[k*ADDR_W +: ADDR_W]]),
      .fwd_we   (wr_active),
      .fwd_addr (wr_addr0),
      .fwd_din  (wr_din0),
      .fwd_be   (wr_be0),
`ifdef MEMBLOCK_PARITY_EN
      .arr_par  (par_mem[rd_addr[k*ADDR_W +: ADDR_W]]),
      .perr     (rd_perr[k]),
`endif
      .dout     (rd_dout[k*WIDTH +: WIDTH]),
      .valid    (rd_valid[k])
    );
  end

endmodule

// File: tb/tb_memblock_mp.sv
// Randomised plus directed bench for memblock_mp against a word-array reference model.
// Build with MEMBLOCK_PARITY_EN to also exercise parity injection.
module tb_memblock_mp;

  localparam int W  = 32;
  localparam int D  = 128;
  localparam int N  = 2;
  localparam int AW = 7;

  logic            clk;
  logic            rst;
  logic            init_busy;
  logic            we0;
  logic [AW-1:0]   wr_addr0;
  logic [W-1:0]    wr_din0;
  logic [W/8-1:0]  wr_be0;
  logic [N-1:0]    rd_en;
  logic [N*AW-1:0] rd_addr;
  logic [N*W-1:0]  rd_dout;
  logic [N-1:0]    rd_valid;
`ifdef MEMBLOCK_PARITY_EN
  logic            wr_perr_inj0;
  logic [N-1:0]    rd_perr;
`endif

  memblock_mp #(
    .WIDTH (W),
    .DEPTH (D),
    .NRD   (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init_busy    (init_busy),
    .we0          (we0),
    .wr_addr0     (wr_addr0),
    .wr_din0      (wr_din0),
    .wr_be0       (wr_be0),
`ifdef MEMBLOCK_PARITY_EN
    .wr_perr_inj0 (wr_perr_inj0),
    .rd_perr      (rd_perr),
`endif
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_dout      (rd_dout),
    .rd_valid     (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain word array plus a countdown of remaining clear cycles.
  logic [W-1:0] model_mem [D];
  bit           par_bad   [D];
  int           remaining = 0;
  logic [W-1:0] exp_dout  [N];
  logic         exp_valid [N];
  logic         exp_perr  [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] merge_bytes(input logic [W-1:0] o, input logic [W-1:0] n,
                                               input logic [W/8-1:0] be);
    for (int i = 0; i < W/8; i++) if (be[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  function automatic logic [AW-1:0] port_addr(input int k);
    return rd_addr[k*AW +: AW];
  endfunction

  task automatic set_raddr(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; wr_be0 = '0; rd_en = '0;
`ifdef MEMBLOCK_PARITY_EN
    wr_perr_inj0 = 1'b0;
`endif
  endtask

  // Advance one clock: predict outputs from the pre-edge model, then check after the edge.
  task automatic cycle();
    logic inj;
    inj = 1'b0;
`ifdef MEMBLOCK_PARITY_EN
    inj = wr_perr_inj0;
`endif
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        exp_valid[k] = 1'b0; exp_dout[k] = '0; exp_perr[k] = 1'b0;
      end else if (remaining > 0 || !rd_en[k]) begin
        exp_valid[k] = 1'b0;
      end else begin
        logic [AW-1:0] a;
        a = port_addr(k);
        exp_valid[k] = 1'b1;
        exp_perr[k]  = par_bad[a];
        exp_dout[k]  = model_mem[a];
        if (we0 && wr_addr0 == a) begin
          exp_dout[k] = merge_bytes(model_mem[a], wr_din0, wr_be0);
          if (wr_be0[0]) exp_perr[k] = 1'b0;
        end
      end
    end
    if (rst) begin
      for (int i = 0; i < D; i++) begin model_mem[i] = '0; par_bad[i] = 0; end
      remaining = D;
    end else if (remaining > 0) begin
      remaining--;
    end else if (we0) begin
      model_mem[wr_addr0] = merge_bytes(model_mem[wr_addr0], wr_din0, wr_be0);
      if (wr_be0[0]) par_bad[wr_addr0] = inj;
    end
    @(posedge clk);
    #1;
    check_eq("init_busy", {63'd0, init_busy}, {63'd0, remaining > 0});
    for (int k = 0; k < N; k++) begin
      check_eq($sformatf("rd_valid[%0d]", k), {63'd0, rd_valid[k]}, {63'd0, exp_valid[k]});
      check_eq($sformatf("rd_dout[%0d]", k), {32'd0, rd_dout[k*W +: W]}, {32'd0, exp_dout[k]});
`ifdef MEMBLOCK_PARITY_EN
      if (exp_valid[k]) check_eq($sformatf("rd_perr[%0d]", k), {63'd0, rd_perr[k]},
                                 {63'd0, exp_perr[k]});
`endif
    end
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] be);
    we0 = 1'b1; wr_addr0 = a; wr_din0 = d; wr_be0 = be;
  endtask

  task automatic wait_ready(input string tag, input int expected_len);
    int n;
    n = 0;
    while (init_busy && n < 1000) begin
      cycle();
      n++;
    end
    check_eq(tag, 64'(n), 64'(expected_len));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    wr_addr0 = '0; wr_din0 = '0; rd_addr = '0;

    // Reset, then the clear sequence must take exactly DEPTH cycles.
    rst = 1'b1;
    cycle();
    cycle();
    check_eq("reset_busy", {63'd0, init_busy}, 64'd1);
    check_eq("reset_valid", {62'd0, rd_valid}, 64'd0);
    rst = 1'b0;
    wait_ready("clear_len", D);

    // Top word of the array reads back as zero.
    rd_en = 2'b01; set_raddr(0, 7'h7F);
    cycle();
    check_eq("rd_7f", {32'd0, rd_dout[31:0]}, 64'd0);
    check_eq("rd_7f_valid", {63'd0, rd_valid[0]}, 64'd1);
    idle();

    // Full write, then both ports read it together.
    write(7'h05, 32'hDEADBEEF, 4'hF);
    cycle();
    idle();
    rd_en = 2'b11; set_raddr(0, 7'h05); set_raddr(1, 7'h05);
    cycle();
    check_eq("dual_p0", {32'd0, rd_dout[31:0]}, 64'hDEADBEEF);
    check_eq("dual_p1", {32'd0, rd_dout[63:32]}, 64'hDEADBEEF);
    idle();

    // Partial write with same-cycle read returns the merged word.
    write(7'h0A, 32'hAABBCCDD, 4'hF);
    cycle();
    write(7'h0A, 32'h11223344, 4'b0101);
    rd_en = 2'b01; set_raddr(0, 7'h0A);
    cycle();
    check_eq("fwd_merge", {32'd0, rd_dout[31:0]}, 64'hAA22CC44);
    idle();
    rd_en = 2'b10; set_raddr(1, 7'h0A);
    cycle();
    check_eq("merge_later", {32'd0, rd_dout[63:32]}, 64'hAA22CC44);
    idle();

    // Back-to-back reads, then rd_en low holds the last data.
    for (int i = 1; i <= 3; i++) begin
      write(AW'(i), 32'h0101_0101 * i, 4'hF);
      cycle();
    end
    idle();
    for (int i = 1; i <= 3; i++) begin
      rd_en = 2'b01; set_raddr(0, AW'(i));
      cycle();
      check_eq("b2b_data", {32'd0, rd_dout[31:0]}, 64'(32'h0101_0101 * i));
    end
    rd_en = 2'b00;
    cycle();
    check_eq("hold_valid", {63'd0, rd_valid[0]}, 64'd0);
    check_eq("hold_data", {32'd0, rd_dout[31:0]}, 64'h03030303);

    // Random traffic biased toward address collisions.
    for (int c = 0; c < 1500; c++) begin
      we0      = 1'($urandom);
      wr_addr0 = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom % 16);
      wr_din0  = $urandom;
      wr_be0   = 4'($urandom);
      rd_en    = 2'($urandom);
      for (int k = 0; k < N; k++) begin
        set_raddr(k, ($urandom % 2 == 0) ? wr_addr0 : AW'($urandom % 16));
      end
      cycle();
    end
    idle();

    // Reset while a read is in flight drops the valid.
    rd_en = 2'b11; rst = 1'b1;
    cycle();
    check_eq("rst_kills_valid", {62'd0, rd_valid}, 64'd0);
    rst = 1'b0;

    // Writes and reads during clear are ignored; reset at clr_cnt=60 restarts clear.
    for (int i = 0; i < 60; i++) begin
      write(AW'(i % 8), 32'hFFFFFFFF, 4'hF);
      rd_en = 2'b11;
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    write(7'h03, 32'hFFFFFFFF, 4'hF);
    rd_en = 2'b11;
    wait_ready("clear_restart_len", D);
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_en = 2'b01; set_raddr(0, AW'(i));
      cycle();
      check_eq("clear_ignores_wr", {32'd0, rd_dout[31:0]}, 64'd0);
    end
    idle();

`ifdef MEMBLOCK_PARITY_EN
    write(7'h20, 32'h000000FF, 4'hF);
    wr_perr_inj0 = 1'b1;
    cycle();
    idle();
    rd_en = 2'b01; set_raddr(0, 7'h20);
    cycle();
    check_eq("perr_injected", {63'd0, rd_perr[0]}, 64'd1);
    idle();
    write(7'h20, 32'h000000FF, 4'hF);
    cycle();
    idle();
    rd_en = 2'b01; set_raddr(0, 7'h20);
    cycle();
    check_eq("perr_cleared", {63'd0, rd_perr[0]}, 64'd0);
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memblock_mp.md
Name: memblock_mp

Overview:
Parametrised successor to the single-port instruction/data memory block: one byte-enabled write port, NRD independent registered read ports, and write-first forwarding. After reset it runs a hardware clear sequence that zeroes every word. It sits behind fetch/load units as instruction or data store; init_busy gates the first fetch.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8
DEPTH, 128, number of words; need not be a power of two
NRD, 2, number of read ports, 1..4
ADDR_W, $clog2(DEPTH), address width; derived, not overridden

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
init_busy  output  1  high while clear sequence runs
we0  input  1  write enable, port 0
wr_addr0  input  ADDR_W  write address
wr_din0  input  WIDTH  write data
wr_be0  input  WIDTH/8  byte enables; bit i covers bits 8i+7:8i
rd_en  input  NRD  per-port read enable
rd_addr  input  NRD*ADDR_W  packed read addresses; port k at slice k
rd_dout  output  NRD*WIDTH  packed registered read data
rd_valid  output  NRD  high one cycle after an accepted read

Behaviour:
- Reset (rst=1 at edge): state<=CLEAR, clr_cnt<=0, init_busy<=1, rd_dout<=0, rd_valid<=0. Array contents not reset directly.
- FSM states: CLEAR, READY.
- CLEAR: each cycle after rst deasserts, write 0 to word clr_cnt, clr_cnt++. At clr_cnt==DEPTH-1 write last word, go READY. Duration exactly DEPTH cycles; init_busy falls on the edge that enters READY.
- In CLEAR: we0 and rd_en ignored; rd_valid stays 0.
- rst asserted mid-CLEAR or in READY: restart CLEAR from 0; pending rd_valid cleared.
- READY write: if we0 and wr_addr0<DEPTH, bytes with wr_be0[i]=1 updated at the edge; others untouched. wr_be0=0 is a no-op.
- READY read: port k with rd_en[k]=1 -> rd_dout slice k and rd_valid[k] updated at the next edge (latency 1). rd_en[k]=0 -> rd_valid[k]<=0, rd_dout slice holds previous value.
- Out-of-range (addr>=DEPTH): write dropped; read returns 0 with rd_valid=1.
- Same-cycle write and read to the same address: write-first. The read returns the merged word: new bytes where wr_be0 is set, old bytes elsewhere. This applies independently to every port.
- Multiple ports reading the same address: all return the same data; no arbitration and no stall.
- Ports are fully pipelined; a new read is accepted every cycle.

Optional Feature:
MEMBLOCK_PARITY_EN
- With macro: array stores one even-parity bit per byte. Adds input wr_perr_inj0 (1), which inverts the stored parity of byte 0 on that write. Adds output rd_perr (NRD), which is valid with rd_valid and is high if any byte of the read word mismatches. Clear writes correct parity. Forwarded reads recompute parity from merged data; they do not flag an injected error until it is read from the array.
- Without macro: no parity storage; ports wr_perr_inj0 and rd_perr are absent.

Decomposition:
- Package memblock_pkg: state enum {CLEAR, READY}; function byte_merge(old, new, be); function byte_parity(word).
- Sub-module memblock_rdport: one registered read port with forwarding compare and out-of-range zeroing. Instantiated NRD times via generate.

Test Plan:
- Reset then release: init_busy high for exactly 128 cycles, then low. A read of addr 0x7F afterwards returns 0x00000000 with rd_valid=1 one cycle later.
- Write 0xDEADBEEF to 0x05 with be=4'hF. Next cycle, read 0x05 on port 0 and port 1 together: both return 0xDEADBEEF.
- Write 0x11223344 to 0x0A with be=4'b0101 over existing 0xAABBCCDD, reading 0x0A in the same cycle: read returns 0xAA22CC44. A later read returns the same value.
- Reads on back-to-back cycles to 0x01, 0x02, 0x03: rd_valid held high for three cycles, data in order. Deassert rd_en: rd_valid=0, rd_dout holds the last data.
- Assert rst for 1 cycle at clr_cnt=60: CLEAR restarts, and init_busy stays high for a further 128 cycles. Writes attempted during CLEAR leave memory at 0.
- (PARITY_EN) Write 0x000000FF with wr_perr_inj0=1, then read it: rd_perr=1. Rewrite without injection: rd_perr=0.
